// File: rtl/spi_controller.sv
// SPI mode-0 write-only initiator: shifts a {1'b1, addr, wdata} frame MSB first; frame plus deselect gap takes 34*CLK_DIV cycles.
// There is no backpressure: start is taken only while idle, and every output is a register.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      nCS     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // Every non-idle phase counts down; the phase-end branches below reload it.
      if (state != IDLE) cnt <= cnt - CW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {1'b1, addr, wdata};
            bit_cnt <= 4'd0;
            cnt     <= CNT_LOAD;
            nCS     <= 1'b0;
            COPI    <= 1'b1;
            busy    <= 1'b1;
            state   <= SETUP;
          end else begin
            // shreg is fully drained after a frame, so this keeps COPI low
            COPI <= shreg[15];
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= CNT_LOAD;
            SCLK  <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (cnt == '0) begin
            cnt   <= CNT_LOAD;
            SCLK  <= 1'b0;
            // Zero fill means the bit after bit 15 is 0, which idles COPI during the hold.
            shreg <= {shreg[14:0], 1'b0};
            COPI  <= shreg[14];
            state <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (cnt == '0) begin
            cnt <= CNT_LOAD;
            if (bit_cnt == 4'd15) begin
              nCS   <= 1'b1;
              state <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              SCLK    <= 1'b1;
              state   <= SHIFT_HI;
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: three instances (CLK_DIV 4/2/8), each with a bus monitor and a five-register peripheral model.
// Directed steps are in one initial block; expected frames are queued when they are sent and popped when the monitor captures them.
module tb_spi_controller;

  logic       clk;
  logic [2:0] rst_n, start, busy, done, sclk, copi, ncs;
  logic [6:0] addr  [3];
  logic [7:0] wdata [3];

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_q [$];
  int rd_idx = 0;

  int   cyc       = 0;
  int   lo_run    = 0, hi_run = 0, b_run = 0;
  int   last_lo   = 0, last_hi = 0, last_busy = 0;
  int   acc_cyc   = 0, done_cyc = 0, done_cnt = 0;
  logic busy_q    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int DIV = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    logic [15:0] sh = '0;
    int          rises = 0;
    int          nframes = 0;
    logic [15:0] got_frame [32];
    int          got_rises [32];
    logic [7:0]  regs [5] = '{default: 8'h00};

    spi_controller #(.CLK_DIV(DIV)) u_dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .start (start[g]),
      .addr  (addr[g]),
      .wdata (wdata[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .SCLK  (sclk[g]),
      .COPI  (copi[g]),
      .nCS   (ncs[g])
    );

    // Peripheral side: sample COPI on SCLK rise, commit on nCS rise unless the frame was aborted by reset.
    always @(posedge sclk[g] or posedge ncs[g]) begin
      if (ncs[g]) begin
        if (rst_n[g] && rises != 0) begin
          if (nframes < 32) begin
            got_frame[nframes] = sh;
            got_rises[nframes] = rises;
          end
          nframes++;
          if (rises == 16 && sh[15] && sh[14:8] < 7'd5) regs[sh[10:8]] = sh[7:0];
        end
        sh    = '0;
        rises = 0;
      end else begin
        sh = {sh[14:0], copi[g]};
        rises++;
      end
    end
  end

  // Cycle-level timing of instance 0, sampled away from the active edge.
  always @(negedge clk) begin
    if (!ncs[0]) lo_run++;
    else begin
      if (lo_run != 0) last_lo = lo_run;
      lo_run = 0;
    end
    if (ncs[0]) hi_run++;
    else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
    end
    if (busy[0]) b_run++;
    else begin
      if (b_run != 0) last_busy = b_run;
      b_run = 0;
    end
    if (busy[0] && !busy_q) acc_cyc = cyc;
    busy_q = busy[0];
    if (done[0]) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int g, input logic [6:0] a, input logic [7:0] d, input bit track);
    @(negedge clk);
    addr[g]  = a;
    wdata[g] = d;
    start[g] = 1'b1;
    if (track) exp_q.push_back({1'b1, a, d});
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string tag);
    int n = 0;
    while (done[g] !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 600), 32'd1);
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (g_inst[0].rises < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, g_inst[0].rises, target);
  endtask

  task automatic check_frames(input string tag);
    logic [15:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < g_inst[0].nframes) begin
        chk({tag, "_frame"}, 32'(g_inst[0].got_frame[rd_idx]), 32'(e));
        chk({tag, "_rises"}, g_inst[0].got_rises[rd_idx], 16);
      end else begin
        chk({tag, "_missing"}, g_inst[0].nframes, rd_idx + 1);
      end
      rd_idx++;
    end
    chk({tag, "_count"}, g_inst[0].nframes, rd_idx);
  endtask

  initial begin
    int d0;
    int f0;
    rst_n = '0;
    start = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ncs",  32'(ncs),  32'h7);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_copi", 32'(copi), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 3'b111;
    repeat (2) @(negedge clk);

    // Single write
    d0 = done_cnt;
    send(0, 7'h02, 8'hA5, 1'b1);
    wait_done(0, "t2_done");
    repeat (3) @(negedge clk);
    check_frames("t2");
    chk("t2_ncs_low",  last_lo, 132);
    chk("t2_latency",  done_cyc - acc_cyc, 136);
    chk("t2_busy_len", last_busy, 136);
    chk("t2_done_cnt", done_cnt - d0, 1);

    // Back-to-back with start held high
    d0 = done_cnt;
    @(negedge clk);
    addr[0] = 7'h00; wdata[0] = 8'h11; start[0] = 1'b1;
    exp_q.push_back(16'h8011);
    @(negedge clk);
    addr[0] = 7'h04; wdata[0] = 8'hEE;
    exp_q.push_back(16'h84EE);
    wait_done(0, "t3_done1");
    @(negedge clk);
    chk("t3_rebusy", 32'(busy[0]), 32'h1);
    start[0] = 1'b0;
    wait_done(0, "t3_done2");
    repeat (3) @(negedge clk);
    check_frames("t3");
    chk("t3_gap",      last_hi, 5);
    chk("t3_done_cnt", done_cnt - d0, 2);

    // start with new operands during bit 6 is ignored
    d0 = done_cnt;
    send(0, 7'h33, 8'h5A, 1'b1);
    wait_rises(7, "t4_bit6");
    addr[0] = 7'h7F; wdata[0] = 8'h00; start[0] = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, "t4_done");
    repeat (3) @(negedge clk);
    check_frames("t4");
    chk("t4_busy_len", last_busy, 136);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_idle",     32'(busy[0]), 32'h0);

    // Asynchronous abort during bit 7
    d0 = done_cnt;
    f0 = g_inst[0].nframes;
    send(0, 7'h55, 8'h77, 1'b0);
    wait_rises(8, "t5_bit7");
    @(posedge clk);
    #3 rst_n[0] = 1'b0;
    #1;
    chk("t5_ncs_async",  32'(ncs[0]),  32'h1);
    chk("t5_sclk_async", 32'(sclk[0]), 32'h0);
    chk("t5_copi_async", 32'(copi[0]), 32'h0);
    chk("t5_busy_async", 32'(busy[0]), 32'h0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_no_done",  done_cnt - d0, 0);
    chk("t5_no_frame", g_inst[0].nframes, f0);
    send(0, 7'h01, 8'h3C, 1'b1);
    wait_done(0, "t5_done");
    repeat (3) @(negedge clk);
    check_frames("t5");
    chk("t5_busy_len", last_busy, 136);

    // Loopback into the register peripheral at three clock ratios
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 5; j++) begin
        send(g, 7'(j), 8'(8'h10 + j), g == 0);
        wait_done(g, "t6_done");
      end
      send(g, 7'h05, 8'hFF, g == 0);
      wait_done(g, "t6_done_a5");
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("t6_div4_reg", 32'(g_inst[0].regs[j]), 32'(8'h10 + j));
      chk("t6_div2_reg", 32'(g_inst[1].regs[j]), 32'(8'h10 + j));
      chk("t6_div8_reg", 32'(g_inst[2].regs[j]), 32'(8'h10 + j));
    end
    chk("t6_div2_frames", g_inst[1].nframes, 6);
    chk("t6_div8_frames", g_inst[2].nframes, 6);
    check_frames("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
